prog_ring_osc_bank: RTL

- Parametrised multi-channel successor to the single fixed-ratio oscillator emulator in the virtual chip.
- CHANNELS independent square-wave generators, each with a runtime-programmable half-period, glitch-free start/stop and a shared global Enable.
- Sits behind the tester's register write path; Q outputs drive chip pins for frequency-measurement tests.

---
 rtl/ring_osc_pkg.sv | 21 ++
 rtl/ring_osc_channel.sv | 103 ++++++++++
 rtl/prog_ring_osc_bank.sv | 45 ++++
 3 files changed

// File: rtl/ring_osc_pkg.sv
// Shared constants and types for the programmable ring-oscillator bank.
// Holds the reset divisor default, the edge-counter width and the per-channel
// state encoding used by ring_osc_channel.
package ring_osc_pkg;

  // Divisor loaded into every channel's shadow and divisor registers at reset.
  localparam int RING_OSC_DEFAULT_DIV = 8;

  // Width of each channel's rising-edge counter on the edge_cnt bus.
  localparam int EDGE_CNT_W = 16;

  // IDLE: parked low.
  // RUN: toggling.
  // STOPPING: counting out the current half-period before parking.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } ch_state_t;

endpackage

// File: rtl/ring_osc_channel.sv
// One oscillator channel: shadow/divisor registers, half-period counter,
// start/stop FSM and, when RING_OSC_EDGE_COUNT_EN is defined, a rising-edge counter.
// Ports: clock, Reset (sync active-low), Enable (global freeze), wr/wr_data
// (decoded shadow write), ch_en (run request), q, active, edge_cnt.
module ring_osc_channel
  import ring_osc_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = RING_OSC_DEFAULT_DIV
) (
  input  logic                  clock,
  input  logic                  Reset,
  input  logic                  Enable,
  input  logic                  wr,
  input  logic [CNT_W-1:0]      wr_data,
  input  logic                  ch_en,
  output logic                  q,
  output logic                  active,
  output logic [EDGE_CNT_W-1:0] edge_cnt
);

  ch_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] div, div_nxt;
  logic [CNT_W-1:0] shadow, shadow_nxt;
  logic             q_nxt;
  logic             tc;

  always_ff @(posedge clock) begin
    if (!Reset) begin
      state  <= IDLE;
      cnt    <= '0;
      div    <= CNT_W'(DEFAULT_DIV);
      shadow <= CNT_W'(DEFAULT_DIV);
      q      <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      div    <= div_nxt;
      shadow <= shadow_nxt;
      q      <= q_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    div_nxt    = div;
    q_nxt      = q;
    shadow_nxt = wr ? wr_data : shadow;
    tc         = (state != IDLE) && Enable && (cnt == div);

    if (state == IDLE) begin
      // Idle channels track the shadow one clock behind, even while frozen.
      div_nxt = shadow;
      if (Enable && ch_en) begin
        state_nxt = RUN;
        cnt_nxt   = '0;
        q_nxt     = 1'b0;
      end
    end else if (Enable) begin
      if (tc) begin
        // The shadow value from before this edge is taken; a write landing on
        // the same edge waits for the next terminal count.
        cnt_nxt = '0;
        div_nxt = shadow;
        if (ch_en) begin
          q_nxt     = ~q;
          state_nxt = RUN;
        end else begin
          // A high half ends with a fall; a low half ends without a rise.
          q_nxt     = 1'b0;
          state_nxt = IDLE;
        end
      end else begin
        cnt_nxt   = cnt + 1'b1;
        state_nxt = ch_en ? RUN : STOPPING;
      end
    end
  end

  assign active = (state != IDLE);

`ifdef RING_OSC_EDGE_COUNT_EN
  logic [EDGE_CNT_W-1:0] ecnt;

  // A divisor write clears the count even if a rising edge coincides.
  always_ff @(posedge clock) begin
    if (!Reset) begin
      ecnt <= '0;
    end else if (wr) begin
      ecnt <= '0;
    end else if (q_nxt && !q) begin
      ecnt <= ecnt + 1'b1;
    end
  end

  assign edge_cnt = ecnt;
`else
  assign edge_cnt = '0;
`endif

endmodule

// File: rtl/prog_ring_osc_bank.sv
// Bank of CHANNELS programmable square-wave generators sharing one write port.
// Ports: clock, Reset (sync active-low), Enable, wr_en/wr_addr/wr_data, ch_en,
// Q, active, edge_cnt (live only with macro RING_OSC_EDGE_COUNT_EN, else 0).
module prog_ring_osc_bank
  import ring_osc_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = RING_OSC_DEFAULT_DIV
) (
  input  logic                                            clock,
  input  logic                                            Reset,
  input  logic                                            Enable,
  input  logic                                            wr_en,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] wr_addr,
  input  logic [CNT_W-1:0]                                wr_data,
  input  logic [CHANNELS-1:0]                             ch_en,
  output logic [CHANNELS-1:0]                             Q,
  output logic [CHANNELS-1:0]                             active,
  output logic [CHANNELS*EDGE_CNT_W-1:0]                  edge_cnt
);

  localparam int ADDR_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  // Addresses at or beyond CHANNELS match no channel, so such writes vanish.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    localparam logic [ADDR_W-1:0] IDX = ADDR_W'(i);

    ring_osc_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clock    (clock),
      .Reset    (Reset),
      .Enable   (Enable),
      .wr       (wr_en && (wr_addr == IDX)),
      .wr_data  (wr_data),
      .ch_en    (ch_en[i]),
      .q        (Q[i]),
      .active   (active[i]),
      .edge_cnt (edge_cnt[i*EDGE_CNT_W +: EDGE_CNT_W])
    );
  end

endmodule
